// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default reset address and instruction opcode field constants.
package fetch_pkg;

    localparam int unsigned XLEN = 16;

    // First instruction address after reset unless overridden.
    localparam logic [XLEN-1:0] FETCH_RESET_IP = 16'h3000;

    // Opcode field position inside an instruction word.
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    // Control-transfer opcodes.
    localparam logic [OPC_W-1:0] OPC_BR  = 4'b1100;
    localparam logic [OPC_W-1:0] OPC_JMP = 4'b1101;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    // Extract the opcode field of an instruction word.
    function automatic logic [OPC_W-1:0] opc_field(input logic [XLEN-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    // True when the instruction is a branch or jump.
    function automatic logic is_ctrl_xfer(input logic [XLEN-1:0] word);
        return (opc_field(word) == OPC_BR) || (opc_field(word) == OPC_JMP);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Fetch timeout counter. Only built when FETCH_TIMEOUT_EN is defined.
// Counts FETCH cycles that end without an ack; expire_c flags the cycle in
// which the TIMEOUT_CYCLES-th unacknowledged FETCH cycle is happening.
`ifdef FETCH_TIMEOUT_EN
module fetch_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic ack_i,
    output logic expire_c
);

    // Counter holds 0..TIMEOUT_CYCLES-1 (cycles already waited).
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Ack wins over expiry on the same cycle.
    assign expire_c = active_i && !ack_i && (count_q == CNT_LAST);

    // Clear outside FETCH or on ack, otherwise count the waited cycle.
    always_comb begin
        count_d = count_q;
        if (!active_i || ack_i) begin
            count_d = '0;
        end else if (count_q != CNT_LAST) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction word at ip, holds it for
// the downstream stage, then loads the successor address supplied by the
// branch/next-IP logic. Optional fetch timeout is enabled by defining
// FETCH_TIMEOUT_EN; without it the unit waits for an ack indefinitely.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_IP       = FETCH_RESET_IP,
    parameter int unsigned     TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] ip,
    output logic [XLEN-1:0] opcode,
    output logic            ir_valid,
    input  logic            ir_ready,
    input  logic [XLEN-1:0] next_ip,
    output logic            fault
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] ip_q, ip_d;
    logic [XLEN-1:0] opcode_q, opcode_d;
    logic            mem_req_q, mem_req_d;
    logic            ir_valid_q, ir_valid_d;
    logic            timeout_c;

`ifdef FETCH_TIMEOUT_EN
    logic            fault_q, fault_d;

    // Wait counter for the current FETCH.
    fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .active_i (state_q == ST_FETCH),
        .ack_i    (mem_ack),
        .expire_c (timeout_c)
    );

    assign fault = fault_q;
`else
    logic            unused_timeout_cfg;

    // No timeout: FETCH waits forever and FAULT is never entered.
    assign timeout_c          = 1'b0;
    assign fault              = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign mem_req  = mem_req_q;
    assign mem_addr = ip_q;
    assign ip       = ip_q;
    assign opcode   = opcode_q;
    assign ir_valid = ir_valid_q;

    // Next state and datapath; registered outputs follow the next state so
    // request and hold never overlap.
    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        opcode_d = opcode_q;

        case (state_q)
            ST_START: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    opcode_d = mem_rdata;
                    state_d  = ST_HOLD;
                end else if (timeout_c) begin
                    state_d = ST_FAULT;
                end
            end
            ST_HOLD: begin
                if (ir_valid_q && ir_ready) begin
                    ip_d    = next_ip;
                    state_d = ST_FETCH;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        mem_req_d  = (state_d == ST_FETCH);
        ir_valid_d = (state_d == ST_HOLD);
`ifdef FETCH_TIMEOUT_EN
        fault_d    = (state_d == ST_FAULT);
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_START;
            ip_q       <= RESET_IP;
            opcode_q   <= '0;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ip_q       <= ip_d;
            opcode_q   <= opcode_d;
            mem_req_q  <= mem_req_d;
            ir_valid_q <= ir_valid_d;
`ifdef FETCH_TIMEOUT_EN
            fault_q    <= fault_d;
`endif
        end
    end

endmodule
